// File: rtl/riscv_cpu_pkg.sv
// Shared types for the RV32 pipeline control path: controller FSM state
// encoding and EX operand forwarding select encoding.
package riscv_cpu_pkg;

    localparam int FWD_SEL_WIDTH = 2;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_FLUSH    = 2'd1,
        CTRL_MEM_WAIT = 2'd2
    } ctrl_state_e;

    typedef enum logic [FWD_SEL_WIDTH-1:0] {
        FWD_REG    = 2'd0,
        FWD_EX_MEM = 2'd1,
        FWD_MEM_WB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Forwarding compare for one EX source operand. The MEM-stage producer wins
// over the WB-stage producer, and register x0 is never forwarded.
module fwd_unit
    import riscv_cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic [ADDR_WIDTH-1:0]    rs_i,
    input  logic                     mem_valid_i,
    input  logic                     mem_reg_we_i,
    input  logic [ADDR_WIDTH-1:0]    mem_rd_i,
    input  logic                     wb_valid_i,
    input  logic                     wb_reg_we_i,
    input  logic [ADDR_WIDTH-1:0]    wb_rd_i,
    output logic [FWD_SEL_WIDTH-1:0] sel_o
);

    logic mem_hit_s;
    logic wb_hit_s;

    // Pick the youngest in-flight producer of rs_i, falling back to the regfile
    always_comb begin
        mem_hit_s = mem_valid_i && mem_reg_we_i && (mem_rd_i != '0) && (mem_rd_i == rs_i);
        wb_hit_s  = wb_valid_i && wb_reg_we_i && (wb_rd_i != '0) && (wb_rd_i == rs_i);
        if (mem_hit_s) begin
            sel_o = FWD_EX_MEM;
        end else if (wb_hit_s) begin
            sel_o = FWD_MEM_WB;
        end else begin
            sel_o = FWD_REG;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline.
// Priority each cycle: data-memory stall > redirect > load-use.
// Outputs are Mealy (state + inputs); the registers are state, return,
// flush_cnt, to_cnt and mem_err.
// Optional build macro PIPE_CTRL_PERF_EN adds stall/redirect event counters.
module pipeline_ctrl
    import riscv_cpu_pkg::*;
#(
    parameter int ADDR_WIDTH    = 5,
    parameter int FETCH_LATENCY = 1,
    parameter int MEM_TIMEOUT   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     id_valid_i,
    input  logic                     id_rs1_used_i,
    input  logic                     id_rs2_used_i,
    input  logic [ADDR_WIDTH-1:0]    id_rs1_i,
    input  logic [ADDR_WIDTH-1:0]    id_rs2_i,
    input  logic                     ex_valid_i,
    input  logic                     ex_reg_we_i,
    input  logic                     ex_is_load_i,
    input  logic [ADDR_WIDTH-1:0]    ex_rs1_i,
    input  logic [ADDR_WIDTH-1:0]    ex_rs2_i,
    input  logic [ADDR_WIDTH-1:0]    ex_rd_i,
    input  logic                     mem_valid_i,
    input  logic                     mem_reg_we_i,
    input  logic                     mem_req_i,
    input  logic                     mem_ready_i,
    input  logic [ADDR_WIDTH-1:0]    mem_rd_i,
    input  logic                     wb_valid_i,
    input  logic                     wb_reg_we_i,
    input  logic [ADDR_WIDTH-1:0]    wb_rd_i,
    input  logic                     redirect_i,
    output logic                     pc_stall_o,
    output logic                     id_stall_o,
    output logic                     ex_stall_o,
    output logic                     mem_stall_o,
    output logic                     id_flush_o,
    output logic                     ex_bubble_o,
    output logic                     wb_bubble_o,
    output logic [FWD_SEL_WIDTH-1:0] fwd_a_sel_o,
    output logic [FWD_SEL_WIDTH-1:0] fwd_b_sel_o,
    output logic                     mem_err_o,
    output logic [1:0]               state_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]              stall_cycles_o,
    output logic [31:0]              flush_events_o
`endif
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX    = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] TO_ERR    = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [2:0]      FL_RELOAD = (FETCH_LATENCY > 0) ? 3'(FETCH_LATENCY - 1) : 3'd0;

    ctrl_state_e     state_q, state_d;
    logic            ret_q, ret_d;           // 1 = return to FLUSH after MEM_WAIT
    logic [2:0]      flush_cnt_q, flush_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            mem_err_q, mem_err_d;

    ctrl_state_e eff_state_s;                // state the pipeline resumes in
    logic        mem_stall_s;
    logic        redirect_acc_s;
    logic        load_use_s;
    logic        lu_match_s;

    logic [FWD_SEL_WIDTH-1:0] fwd_a_raw_s;
    logic [FWD_SEL_WIDTH-1:0] fwd_b_raw_s;

    fwd_unit #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd_a (
        .rs_i         (ex_rs1_i),
        .mem_valid_i  (mem_valid_i),
        .mem_reg_we_i (mem_reg_we_i),
        .mem_rd_i     (mem_rd_i),
        .wb_valid_i   (wb_valid_i),
        .wb_reg_we_i  (wb_reg_we_i),
        .wb_rd_i      (wb_rd_i),
        .sel_o        (fwd_a_raw_s)
    );

    fwd_unit #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd_b (
        .rs_i         (ex_rs2_i),
        .mem_valid_i  (mem_valid_i),
        .mem_reg_we_i (mem_reg_we_i),
        .mem_rd_i     (mem_rd_i),
        .wb_valid_i   (wb_valid_i),
        .wb_reg_we_i  (wb_reg_we_i),
        .wb_rd_i      (wb_rd_i),
        .sel_o        (fwd_b_raw_s)
    );

    // Hazard classification with memory > redirect > load-use priority
    always_comb begin
        mem_stall_s = mem_valid_i && mem_req_i && !mem_ready_i;
        if (state_q == CTRL_MEM_WAIT) begin
            eff_state_s = ret_q ? CTRL_FLUSH : CTRL_RUN;
        end else begin
            eff_state_s = state_q;
        end
        lu_match_s = id_valid_i && ex_valid_i && ex_reg_we_i && ex_is_load_i &&
                     (ex_rd_i != '0) &&
                     ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                      (id_rs2_used_i && (id_rs2_i == ex_rd_i)));
        redirect_acc_s = !mem_stall_s && redirect_i;
        // ID holds a discarded fetch in FLUSH, so load-use only counts in RUN
        load_use_s = !mem_stall_s && !redirect_i && (eff_state_s == CTRL_RUN) && lu_match_s;
    end

    // Drive per-stage controls; everything is quiet while reset is held
    always_comb begin
        if (rst_i) begin
            pc_stall_o  = 1'b0;
            id_stall_o  = 1'b0;
            ex_stall_o  = 1'b0;
            mem_stall_o = 1'b0;
            id_flush_o  = 1'b0;
            ex_bubble_o = 1'b0;
            wb_bubble_o = 1'b0;
            fwd_a_sel_o = FWD_REG;
            fwd_b_sel_o = FWD_REG;
        end else begin
            pc_stall_o  = mem_stall_s || load_use_s;
            id_stall_o  = mem_stall_s || load_use_s;
            ex_stall_o  = mem_stall_s;
            mem_stall_o = mem_stall_s;
            id_flush_o  = !mem_stall_s && (redirect_acc_s || (eff_state_s == CTRL_FLUSH));
            ex_bubble_o = redirect_acc_s || load_use_s;
            wb_bubble_o = mem_stall_s;
            fwd_a_sel_o = fwd_a_raw_s;
            fwd_b_sel_o = fwd_b_raw_s;
        end
        mem_err_o = mem_err_q;
        state_o   = state_q;
    end

    // Next-state logic for the RUN / FLUSH / MEM_WAIT sequencer
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        flush_cnt_d = flush_cnt_q;
        to_cnt_d    = to_cnt_q;
        mem_err_d   = mem_err_q;
        if (mem_stall_s) begin
            state_d = CTRL_MEM_WAIT;
            if (state_q == CTRL_MEM_WAIT) begin
                if (to_cnt_q != TO_MAX) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end else begin
                    to_cnt_d = to_cnt_q;
                end
                if (to_cnt_q == TO_ERR) begin
                    mem_err_d = 1'b1;
                end else begin
                    mem_err_d = mem_err_q;
                end
            end else begin
                ret_d    = (state_q == CTRL_FLUSH);
                to_cnt_d = '0;
            end
        end else if (redirect_i) begin
            if (FETCH_LATENCY > 0) begin
                state_d     = CTRL_FLUSH;
                flush_cnt_d = FL_RELOAD;
            end else begin
                state_d     = CTRL_RUN;
                flush_cnt_d = flush_cnt_q;
            end
        end else if (eff_state_s == CTRL_FLUSH) begin
            if (flush_cnt_q == 3'd0) begin
                state_d = CTRL_RUN;
            end else begin
                state_d     = CTRL_FLUSH;
                flush_cnt_d = flush_cnt_q - 3'd1;
            end
        end else begin
            state_d = CTRL_RUN;
        end
    end

    // Controller state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= CTRL_RUN;
            ret_q       <= 1'b0;
            flush_cnt_q <= 3'd0;
            to_cnt_q    <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            flush_cnt_q <= flush_cnt_d;
            to_cnt_q    <= to_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_events_q;

    // Free-running wrap-around event counters for stalled PC cycles and redirects
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cycles_q <= 32'd0;
            flush_events_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_q + {31'd0, pc_stall_o};
            flush_events_q <= flush_events_q + {31'd0, redirect_acc_s};
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_events_o = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl built with FETCH_LATENCY=2, MEM_TIMEOUT=4.
// Inputs change on the falling edge; Mealy outputs are sampled a step later.
module tb_pipeline_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       id_valid_i, id_rs1_used_i, id_rs2_used_i;
    logic [4:0] id_rs1_i, id_rs2_i;
    logic       ex_valid_i, ex_reg_we_i, ex_is_load_i;
    logic [4:0] ex_rs1_i, ex_rs2_i, ex_rd_i;
    logic       mem_valid_i, mem_reg_we_i, mem_req_i, mem_ready_i;
    logic [4:0] mem_rd_i;
    logic       wb_valid_i, wb_reg_we_i;
    logic [4:0] wb_rd_i;
    logic       redirect_i;
    logic       pc_stall_o, id_stall_o, ex_stall_o, mem_stall_o;
    logic       id_flush_o, ex_bubble_o, wb_bubble_o;
    logic [1:0] fwd_a_sel_o, fwd_b_sel_o;
    logic       mem_err_o;
    logic [1:0] state_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_o, flush_events_o;
`endif

    int vectors;
    int miscompares;

    logic [6:0] ctl_s;
    logic [3:0] fwd_s;
    assign ctl_s = {pc_stall_o, id_stall_o, ex_stall_o, mem_stall_o, id_flush_o, ex_bubble_o, wb_bubble_o};
    assign fwd_s = {fwd_a_sel_o, fwd_b_sel_o};

    localparam logic [6:0] CTL_NONE  = 7'b0000000;
    localparam logic [6:0] CTL_LU    = 7'b1100010;
    localparam logic [6:0] CTL_REDIR = 7'b0000110;
    localparam logic [6:0] CTL_FLUSH = 7'b0000100;
    localparam logic [6:0] CTL_MEMST = 7'b1111001;

    always #5 clk_i = ~clk_i;

    pipeline_ctrl #(
        .ADDR_WIDTH    (5),
        .FETCH_LATENCY (2),
        .MEM_TIMEOUT   (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .ex_valid_i    (ex_valid_i),
        .ex_reg_we_i   (ex_reg_we_i),
        .ex_is_load_i  (ex_is_load_i),
        .ex_rs1_i      (ex_rs1_i),
        .ex_rs2_i      (ex_rs2_i),
        .ex_rd_i       (ex_rd_i),
        .mem_valid_i   (mem_valid_i),
        .mem_reg_we_i  (mem_reg_we_i),
        .mem_req_i     (mem_req_i),
        .mem_ready_i   (mem_ready_i),
        .mem_rd_i      (mem_rd_i),
        .wb_valid_i    (wb_valid_i),
        .wb_reg_we_i   (wb_reg_we_i),
        .wb_rd_i       (wb_rd_i),
        .redirect_i    (redirect_i),
        .pc_stall_o    (pc_stall_o),
        .id_stall_o    (id_stall_o),
        .ex_stall_o    (ex_stall_o),
        .mem_stall_o   (mem_stall_o),
        .id_flush_o    (id_flush_o),
        .ex_bubble_o   (ex_bubble_o),
        .wb_bubble_o   (wb_bubble_o),
        .fwd_a_sel_o   (fwd_a_sel_o),
        .fwd_b_sel_o   (fwd_b_sel_o),
        .mem_err_o     (mem_err_o),
        .state_o       (state_o)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles_o(stall_cycles_o),
        .flush_events_o(flush_events_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        id_valid_i = 1'b0; id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0;
        id_rs1_i = 5'd0; id_rs2_i = 5'd0;
        ex_valid_i = 1'b0; ex_reg_we_i = 1'b0; ex_is_load_i = 1'b0;
        ex_rs1_i = 5'd0; ex_rs2_i = 5'd0; ex_rd_i = 5'd0;
        mem_valid_i = 1'b0; mem_reg_we_i = 1'b0; mem_req_i = 1'b0; mem_ready_i = 1'b0;
        mem_rd_i = 5'd0;
        wb_valid_i = 1'b0; wb_reg_we_i = 1'b0; wb_rd_i = 5'd0;
        redirect_i = 1'b0;
    endtask

    // Consumer in ID reading rs1=x5 while a load to x5 sits in EX
    task automatic set_load_use();
        id_valid_i = 1'b1; id_rs1_used_i = 1'b1; id_rs1_i = 5'd5;
        ex_valid_i = 1'b1; ex_reg_we_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = 5'd5;
    endtask

    task automatic set_mem_stall();
        mem_valid_i = 1'b1; mem_req_i = 1'b1; mem_ready_i = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_i = 1'b1;
        clr();
        #2;
        chk("reset_ctl", {25'd0, ctl_s}, {25'd0, CTL_NONE});
        chk("reset_fwd", {28'd0, fwd_s}, 32'd0);
        chk("reset_err", {31'd0, mem_err_o}, 32'd0);
        chk("reset_state", {30'd0, state_o}, 32'd0);
        // hazardous inputs while reset is held must not leak through
        set_mem_stall(); redirect_i = 1'b1; set_load_use();
        mem_reg_we_i = 1'b1; mem_rd_i = 5'd3; ex_rs1_i = 5'd3;
        #1;
        chk("reset_hold_ctl", {25'd0, ctl_s}, {25'd0, CTL_NONE});
        chk("reset_hold_fwd", {28'd0, fwd_s}, 32'd0);
        @(negedge clk_i); rst_i = 1'b0; clr();
        @(negedge clk_i);

        // ---- load-use on rs1, then release and WB forwarding
        set_load_use();
        #1;
        chk("lu_ctl", {25'd0, ctl_s}, {25'd0, CTL_LU});
        chk("lu_state", {30'd0, state_o}, 32'd0);
        @(negedge clk_i);
        clr();
        id_valid_i = 1'b1; id_rs1_used_i = 1'b1; id_rs1_i = 5'd5;
        mem_valid_i = 1'b1; mem_reg_we_i = 1'b1; mem_rd_i = 5'd5; mem_req_i = 1'b1; mem_ready_i = 1'b1;
        #1;
        chk("lu_release_ctl", {25'd0, ctl_s}, {25'd0, CTL_NONE});
        @(negedge clk_i);
        clr();
        ex_valid_i = 1'b1; ex_rs1_i = 5'd5; ex_rs2_i = 5'd7;
        wb_valid_i = 1'b1; wb_reg_we_i = 1'b1; wb_rd_i = 5'd5;
        #1;
        chk("lu_fwd_wb", {28'd0, fwd_s}, {28'd0, 4'b1000});
        @(negedge clk_i);

        // ---- forwarding priority and x0
        clr();
        ex_valid_i = 1'b1; ex_rs1_i = 5'd3; ex_rs2_i = 5'd3;
        mem_valid_i = 1'b1; mem_reg_we_i = 1'b1; mem_rd_i = 5'd3;
        wb_valid_i = 1'b1; wb_reg_we_i = 1'b1; wb_rd_i = 5'd3;
        #1;
        chk("fwd_mem_prio", {28'd0, fwd_s}, {28'd0, 4'b0101});
        mem_reg_we_i = 1'b0;
        #1;
        chk("fwd_wb_only", {28'd0, fwd_s}, {28'd0, 4'b1010});
        mem_reg_we_i = 1'b1; mem_rd_i = 5'd0; wb_rd_i = 5'd0; ex_rs1_i = 5'd0; ex_rs2_i = 5'd0;
        #1;
        chk("fwd_x0", {28'd0, fwd_s}, 32'd0);
        @(negedge clk_i);
        clr();
        set_load_use(); ex_rd_i = 5'd0; id_rs1_i = 5'd0;
        #1;
        chk("lu_x0_ctl", {25'd0, ctl_s}, {25'd0, CTL_NONE});
        ex_rd_i = 5'd9; id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b1; id_rs2_i = 5'd9;
        #1;
        chk("lu_rs2_ctl", {25'd0, ctl_s}, {25'd0, CTL_LU});
        id_rs2_used_i = 1'b0;
        #1;
        chk("lu_rs2_unused_ctl", {25'd0, ctl_s}, {25'd0, CTL_NONE});
        @(negedge clk_i);

        // ---- redirect with concurrent load-use, FETCH_LATENCY=2
        clr(); set_load_use(); redirect_i = 1'b1;
        #1;
        chk("redir_ctl", {25'd0, ctl_s}, {25'd0, CTL_REDIR});
        chk("redir_state", {30'd0, state_o}, 32'd0);
        @(negedge clk_i);
        redirect_i = 1'b0;
        #1;
        chk("flush1_state", {30'd0, state_o}, 32'd1);
        chk("flush1_ctl", {25'd0, ctl_s}, {25'd0, CTL_FLUSH});
        @(negedge clk_i);
        #1;
        chk("flush2_state", {30'd0, state_o}, 32'd1);
        chk("flush2_ctl", {25'd0, ctl_s}, {25'd0, CTL_FLUSH});
        @(negedge clk_i);
        #1;
        chk("flush_exit_state", {30'd0, state_o}, 32'd0);
        chk("flush_exit_lu_ctl", {25'd0, ctl_s}, {25'd0, CTL_LU});
        @(negedge clk_i);

        // ---- memory wait with redirect pending, then redirect accepted on ready
        clr(); set_mem_stall(); redirect_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_ctl", {25'd0, ctl_s}, {25'd0, CTL_MEMST});
            chk("mw_state", {30'd0, state_o}, (i == 0) ? 32'd0 : 32'd2);
            @(negedge clk_i);
        end
        mem_ready_i = 1'b1;
        #1;
        chk("mw_ready_ctl", {25'd0, ctl_s}, {25'd0, CTL_REDIR});
        chk("mw_ready_state", {30'd0, state_o}, 32'd2);
        @(negedge clk_i);
        clr();
        #1;
        chk("mw_after_state", {30'd0, state_o}, 32'd1);
        chk("mw_after_ctl", {25'd0, ctl_s}, {25'd0, CTL_FLUSH});
        chk("mw_after_err", {31'd0, mem_err_o}, 32'd0);
        @(negedge clk_i);
        #1;
        chk("mw_flush2_state", {30'd0, state_o}, 32'd1);
        @(negedge clk_i);
        #1;
        chk("mw_run_state", {30'd0, state_o}, 32'd0);
        @(negedge clk_i);

        // ---- timeout, MEM_TIMEOUT=4: err registers at the end of the 4th wait cycle
        set_mem_stall();
        #1;
        chk("to_entry_state", {30'd0, state_o}, 32'd0);
        chk("to_entry_err", {31'd0, mem_err_o}, 32'd0);
        @(negedge clk_i);
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("to_wait_state", {30'd0, state_o}, 32'd2);
            chk("to_wait_err", {31'd0, mem_err_o}, 32'd0);
            @(negedge clk_i);
        end
        #1;
        chk("to_err_set", {31'd0, mem_err_o}, 32'd1);
        chk("to_err_ctl", {25'd0, ctl_s}, {25'd0, CTL_MEMST});
        mem_ready_i = 1'b1;
        #1;
        chk("to_ready_ctl", {25'd0, ctl_s}, {25'd0, CTL_NONE});
        chk("to_ready_err", {31'd0, mem_err_o}, 32'd1);
        @(negedge clk_i);
        clr();
        #1;
        chk("to_sticky_err", {31'd0, mem_err_o}, 32'd1);
        chk("to_return_state", {30'd0, state_o}, 32'd0);
        @(negedge clk_i);

        // ---- reset mid-FLUSH clears everything including the sticky error
        redirect_i = 1'b1;
        @(negedge clk_i);
        redirect_i = 1'b0;
        #1;
        chk("rstf_pre_state", {30'd0, state_o}, 32'd1);
        chk("rstf_pre_err", {31'd0, mem_err_o}, 32'd1);
        rst_i = 1'b1;
        set_mem_stall(); redirect_i = 1'b1;
        ex_rs1_i = 5'd4; mem_reg_we_i = 1'b1; mem_rd_i = 5'd4;
        #1;
        chk("rstf_ctl", {25'd0, ctl_s}, {25'd0, CTL_NONE});
        chk("rstf_fwd", {28'd0, fwd_s}, 32'd0);
        chk("rstf_state", {30'd0, state_o}, 32'd0);
        chk("rstf_err", {31'd0, mem_err_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0; clr();
        @(negedge clk_i);

        // ---- reset mid-MEM_WAIT
        set_mem_stall();
        @(negedge clk_i);
        #1;
        chk("rstm_pre_state", {30'd0, state_o}, 32'd2);
        chk("rstm_pre_ctl", {25'd0, ctl_s}, {25'd0, CTL_MEMST});
        rst_i = 1'b1;
        #1;
        chk("rstm_ctl", {25'd0, ctl_s}, {25'd0, CTL_NONE});
        chk("rstm_state", {30'd0, state_o}, 32'd0);
        chk("rstm_err", {31'd0, mem_err_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0; clr();
        #1;
        chk("rstm_post_state", {30'd0, state_o}, 32'd0);
        @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
